voice_allocator: RTL and testbench
==================================

Name: voice_allocator

Overview:
- Polyphony controller in front of phase_bank_p.
- Accepts note-on/note-off events over a valid/ready handshake and maintains a table of NBANKS voice slots, each holding a MIDI note (0 = silent).
- Drives the time-multiplexed per-slot note stream consumed by the phase bank; slot order matches the phase bank's internal bank index.

Parameters:
- NBANKS, 10, number of voice slots; must equal the phase bank's NBANKS.
- SLOT_W, 4, width of slot index; must satisfy 2^SLOT_W >= NBANKS.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- clk_en  in  1  sample-rate enable; advances the output stream only.
- i_valid  in  1  event request.
- o_ready  out  1  allocator can accept an event.
- i_note_on  in  1  1 = note-on, 0 = note-off; qualified by i_valid.
- i_note  in  7  MIDI note number.
- o_midi  out  7  note for slot o_slot; connects to phase bank i_midi.
- o_slot  out  SLOT_W  slot index currently presented on o_midi.
- o_active  out  NBANKS  bit k = 1 when slot k holds a nonzero note.
- o_full  out  1  all slots occupied.
- o_drop  out  1  one-cycle pulse: note-on discarded.

Behaviour:
- Reset values:
  - o_midi=0, o_slot=NBANKS-1, o_ready=1, o_active=0, o_full=0, o_drop=0.
  - All table entries 0, steal pointer 0, FSM in IDLE.
  - Reset is synchronous and overrides everything, including an FSM mid-scan; any in-flight event is lost.
- Stream:
  - On each clk edge with clk_en=1, o_slot advances (NBANKS-1 wraps to 0) and o_midi takes table[new o_slot]. Both are registered and hold when clk_en=0.
  - Consequence: the first clk_en edge after reset presents slot 0, aligned with the phase bank's index sequence (bank NBANKS-1 first).
- Handshake:
  - An event is accepted on a clk edge with i_valid && o_ready.
  - i_note_on and i_note are captured at acceptance.
  - o_ready falls the next cycle and stays low until the FSM returns to IDLE.
- FSM (runs every clk, independent of clk_en):
  - IDLE: on accept, go to SCAN with scan index 0 and the match/free flags cleared.
  - SCAN: one slot per cycle for NBANKS cycles. Record:
    - note match: any slot equal to the captured note; for note-off, accumulate a mask of matching slots.
    - lowest free slot: entry == 0.
    - After index NBANKS-1, go to APPLY.
  - APPLY: single cycle, table write per the rules below, then go to IDLE. o_ready is high the following cycle.
  - Latency: accept at cycle 0, SCAN cycles 1..NBANKS, APPLY at NBANKS+1, o_ready=1 at NBANKS+2.
- Apply rules:
  - Note-on, note 0: no change, no drop.
  - Note-on, note already in table: no change (no duplicate voice).
  - Note-on, free slot exists: write the note to the lowest free slot.
  - Note-on, no free slot: see the optional feature.
  - Note-off: clear every matching slot to 0. If there is no match, or note 0 is given, no change.
- Table/stream collision:
  - The stream read at an edge coincident with the APPLY write sees the pre-write value.
  - The new value appears from the next visit of that slot.
- o_active and o_full are registered from the table and update the cycle after APPLY.

Optional Feature:
- Macro: VOICE_STEAL_EN
- Defined:
  - A note-on with no free slot overwrites table[steal_ptr].
  - steal_ptr then increments modulo NBANKS.
  - o_drop stays 0.
- Undefined:
  - A note-on with no free slot is discarded and o_drop pulses for one cycle, the cycle after APPLY.
  - No steal pointer is implemented.

Test Plan:
- Reset release: rst 1 then 0, then clk_en every cycle → o_slot sequence 0,1,...,9,0; o_midi=0 throughout; o_ready=1; o_active=0.
- Single note-on 0x3C, clk_en low: o_ready low for cycles 1..11, high at cycle 12; table[0]=0x3C. Then assert clk_en until slot 0 is presented → o_midi=0x3C when o_slot=0; o_active=0x001.
- Note-ons 0x3C, 0x40, 0x3C, 0x43 → slots 0,1,2 = 0x3C,0x40,0x43; the duplicate 0x3C is ignored; o_active=0x007.
- Fill all 10 slots with 0x30..0x39, then note-on 0x50:
  - Undefined build: o_drop pulses once; table unchanged; o_full=1.
  - Defined build: slot 0=0x50, steal_ptr=1. A further 0x51 goes to slot 1.
- Note-off 0x40 with 0x40 in slot 1: slot 1 cleared, o_active bit 1 falls. Next note-on 0x45 lands in slot 1 (lowest free). Note-off 0x7F (absent) → no change.
- Assert rst during SCAN of a note-on → no table write; all outputs at reset values; o_ready=1 on the first cycle after rst deasserts.

Source files
------------

// File: rtl/voice_allocator.sv
// Polyphony controller: NBANKS-slot note table feeding phase_bank_p's time-multiplexed note stream.
// Optional build macro VOICE_STEAL_EN: a note-on with a full table overwrites a round-robin victim slot instead of being dropped.
module voice_allocator #(
  parameter int NBANKS = 10,
  parameter int SLOT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_note_on,
  input  logic [6:0]        i_note,
  output logic [6:0]        o_midi,
  output logic [SLOT_W-1:0] o_slot,
  output logic [NBANKS-1:0] o_active,
  output logic              o_full,
  output logic              o_drop
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SCAN  = 2'd1;
  localparam logic [1:0] APPLY = 2'd2;
  localparam logic [SLOT_W-1:0] LAST = SLOT_W'(NBANKS - 1);

  logic [1:0]        state;
  logic [6:0]        tbl      [NBANKS];
  logic [6:0]        tbl_next [NBANKS];
  logic [SLOT_W-1:0] scan_idx;
  logic [SLOT_W-1:0] free_idx;
  logic [SLOT_W-1:0] next_slot;
  logic              cap_on;
  logic [6:0]        cap_note;
  logic              match;
  logic              free_found;
  logic [NBANKS-1:0] match_mask;
  logic              drop_next;
  logic [NBANKS-1:0] active_next;
`ifdef VOICE_STEAL_EN
  logic [SLOT_W-1:0] steal_ptr;
`endif

  assign o_ready   = (state == IDLE);
  assign next_slot = (o_slot == LAST) ? '0 : o_slot + SLOT_W'(1);

  // Output stream reads the registered table, so an edge coincident with an APPLY write sees the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_slot <= LAST;
      o_midi <= '0;
    end else if (clk_en) begin
      o_slot <= next_slot;
      o_midi <= tbl[next_slot];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      scan_idx   <= '0;
      cap_on     <= 1'b0;
      cap_note   <= '0;
      match      <= 1'b0;
      free_found <= 1'b0;
      free_idx   <= '0;
      match_mask <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            state      <= SCAN;
            scan_idx   <= '0;
            cap_on     <= i_note_on;
            cap_note   <= i_note;
            match      <= 1'b0;
            free_found <= 1'b0;
            match_mask <= '0;
          end
        end
        SCAN: begin
          if (tbl[scan_idx] == cap_note) begin
            match                <= 1'b1;
            match_mask[scan_idx] <= 1'b1;
          end
          if ((tbl[scan_idx] == 7'd0) && !free_found) begin
            free_found <= 1'b1;
            free_idx   <= scan_idx;
          end
          if (scan_idx == LAST) state <= APPLY;
          else                  scan_idx <= scan_idx + SLOT_W'(1);
        end
        APPLY:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Note 0 is the silent marker, so it is never written nor used to clear slots.
  always_comb begin
    for (int k = 0; k < NBANKS; k++) tbl_next[k] = tbl[k];
    drop_next = 1'b0;
    if ((state == APPLY) && (cap_note != 7'd0)) begin
      if (!cap_on) begin
        for (int k = 0; k < NBANKS; k++)
          if (match_mask[k]) tbl_next[k] = '0;
      end else if (!match) begin
        if (free_found) begin
          tbl_next[free_idx] = cap_note;
        end else begin
`ifdef VOICE_STEAL_EN
          tbl_next[steal_ptr] = cap_note;
`else
          drop_next = 1'b1;
`endif
        end
      end
    end
    for (int k = 0; k < NBANKS; k++) active_next[k] = (tbl_next[k] != 7'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NBANKS; k++) tbl[k] <= '0;
      o_active <= '0;
      o_full   <= 1'b0;
      o_drop   <= 1'b0;
    end else begin
      for (int k = 0; k < NBANKS; k++) tbl[k] <= tbl_next[k];
      o_active <= active_next;
      o_full   <= &active_next;
      o_drop   <= drop_next;
    end
  end

`ifdef VOICE_STEAL_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      steal_ptr <= '0;
    end else if ((state == APPLY) && cap_on && (cap_note != 7'd0) && !match && !free_found) begin
      steal_ptr <= (steal_ptr == LAST) ? '0 : steal_ptr + SLOT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: behavioural table model compared every cycle, plus directed literal checks.
// Honours VOICE_STEAL_EN the same way the design does.
module tb_voice_allocator;
  localparam int NB = 10;

  logic       clk;
  logic       rst;
  logic       clk_en;
  logic       i_valid;
  logic       o_ready;
  logic       i_note_on;
  logic [6:0] i_note;
  logic [6:0] o_midi;
  logic [3:0] o_slot;
  logic [NB-1:0] o_active;
  logic       o_full;
  logic       o_drop;

  voice_allocator #(.NBANKS(NB), .SLOT_W(4)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .i_valid(i_valid), .o_ready(o_ready),
    .i_note_on(i_note_on), .i_note(i_note), .o_midi(o_midi), .o_slot(o_slot),
    .o_active(o_active), .o_full(o_full), .o_drop(o_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int drop_seen = 0;
  bit rand_clk = 1'b0;

  // Reference model: whole-table view, event resolved NB+1 edges after acceptance.
  int m_tbl [NB];
  int m_steal, m_slot, m_midi, m_cnt, m_note, m_active;
  bit m_busy, m_on, m_drop, m_full, model_ok = 1'b0;

  function automatic void modelApply();
    int free_k = -1;
    bit hit = 1'b0;
    if (m_note == 0) return;
    for (int k = 0; k < NB; k++) begin
      if (m_tbl[k] == m_note) hit = 1'b1;
      if (m_tbl[k] == 0 && free_k < 0) free_k = k;
    end
    if (!m_on) begin
      for (int k = 0; k < NB; k++) if (m_tbl[k] == m_note) m_tbl[k] = 0;
    end else if (!hit) begin
      if (free_k >= 0) m_tbl[free_k] = m_note;
      else begin
`ifdef VOICE_STEAL_EN
        m_tbl[m_steal] = m_note;
        m_steal = (m_steal + 1) % NB;
`else
        m_drop = 1'b1;
`endif
      end
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NB; k++) m_tbl[k] = 0;
      m_steal = 0; m_slot = NB - 1; m_midi = 0; m_busy = 0; m_cnt = 0;
      m_drop = 0; model_ok = 1'b1;
    end else begin
      m_drop = 1'b0;
      if (clk_en) begin
        m_slot = (m_slot + 1) % NB;
        m_midi = m_tbl[m_slot];
      end
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          modelApply();
          m_busy = 1'b0;
        end
      end else if (i_valid) begin
        m_busy = 1'b1; m_cnt = NB + 1; m_on = i_note_on; m_note = int'(i_note);
      end
    end
    m_active = 0;
    for (int k = 0; k < NB; k++) if (m_tbl[k] != 0) m_active |= (1 << k);
    m_full = (m_active == (1 << NB) - 1);
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (rand_clk) clk_en = 1'($urandom_range(0, 1));
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1; i_valid = 1'b0; clk_en = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input bit on, input int note);
    int waited = 0;
    tick();
    i_valid = 1'b1; i_note_on = on; i_note = 7'(note);
    while (!o_ready && waited < 50) begin tick(); waited++; end
    if (!o_ready) checkOutput("accept_timeout", 0, 1);
    tick();
    i_valid = 1'b0;
  endtask

  task automatic waitIdle(output int low);
    low = 0;
    while (!o_ready && low < 100) begin low++; tick(); end
    if (!o_ready) checkOutput("idle_timeout", 0, 1);
  endtask

  task automatic presentSlot(input int k, input int expected, input string name);
    int n = 0;
    clk_en = 1'b1;
    do begin tick(); n++; end while (int'(o_slot) != k && n < 2 * NB);
    clk_en = 1'b0;
    checkOutput(name, int'(o_midi), expected);
  endtask

  int low, d0;

  initial begin
    rst = 1'b1; clk_en = 1'b0; i_valid = 1'b0; i_note_on = 1'b0; i_note = '0;
    fork
      forever begin
        @(negedge clk);
        if (model_ok) begin
          checks++;
          if (int'(o_slot) != m_slot || int'(o_midi) != m_midi || o_ready != !m_busy ||
              int'(o_active) != m_active || o_full != m_full || o_drop != m_drop) begin
            failures++;
            $display("[TB] FAIL cycle_compare t=%0t slot=%0d/%0d midi=%0h/%0h ready=%0b/%0b active=%0h/%0h full=%0b/%0b drop=%0b/%0b",
                     $time, o_slot, m_slot, o_midi, m_midi, o_ready, !m_busy, o_active, m_active,
                     o_full, m_full, o_drop, m_drop);
          end
        end
        if (o_drop) drop_seen++;
      end
    join_none

    doReset();
    checkOutput("reset_slot", int'(o_slot), 9);
    checkOutput("reset_ready", int'(o_ready), 1);
    clk_en = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick();
      checkOutput("reset_seq_slot", int'(o_slot), i % 10);
      checkOutput("reset_seq_midi", int'(o_midi), 0);
    end
    clk_en = 1'b0;
    checkOutput("reset_active", int'(o_active), 0);

    $display("[TB] single note-on");
    doReset();
    applyStimulus(1, 'h3C);
    waitIdle(low);
    checkOutput("ready_low_cycles", low, 11);
    checkOutput("single_active", int'(o_active), 'h001);
    presentSlot(0, 'h3C, "single_slot0");

    $display("[TB] duplicate suppression");
    doReset();
    applyStimulus(1, 'h3C); applyStimulus(1, 'h40); applyStimulus(1, 'h3C); applyStimulus(1, 'h43);
    waitIdle(low);
    checkOutput("dup_active", int'(o_active), 'h007);
    presentSlot(2, 'h43, "dup_slot2");

    $display("[TB] full table");
    doReset();
    for (int n = 0; n < NB; n++) applyStimulus(1, 'h30 + n);
    waitIdle(low);
    checkOutput("fill_full", int'(o_full), 1);
    d0 = drop_seen;
    applyStimulus(1, 'h50);
    waitIdle(low);
    tick(); tick();
`ifdef VOICE_STEAL_EN
    checkOutput("steal_drops", drop_seen - d0, 0);
    presentSlot(0, 'h50, "steal_slot0");
    applyStimulus(1, 'h51);
    waitIdle(low);
    presentSlot(1, 'h51, "steal_slot1");
`else
    checkOutput("drop_pulses", drop_seen - d0, 1);
    presentSlot(0, 'h30, "drop_slot0");
`endif
    checkOutput("full_after", int'(o_full), 1);

    $display("[TB] note-off");
    doReset();
    applyStimulus(1, 'h3C); applyStimulus(1, 'h40); applyStimulus(1, 'h43);
    applyStimulus(0, 'h40);
    waitIdle(low);
    checkOutput("off_active", int'(o_active), 'h005);
    applyStimulus(1, 'h45);
    waitIdle(low);
    presentSlot(1, 'h45, "refill_slot1");
    applyStimulus(0, 'h7F);
    waitIdle(low);
    checkOutput("absent_off_active", int'(o_active), 'h007);

    $display("[TB] reset during scan");
    applyStimulus(1, 'h20);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    checkOutput("rst_scan_ready", int'(o_ready), 1);
    checkOutput("rst_scan_active", int'(o_active), 0);
    checkOutput("rst_scan_slot", int'(o_slot), 9);

    $display("[TB] random events");
    doReset();
    rand_clk = 1'b1;
    for (int e = 0; e < 150; e++) begin
      int gap = $urandom_range(0, 2);
      int note = ($urandom_range(0, 15) == 0) ? 0 : 'h30 + $urandom_range(0, 11);
      for (int g = 0; g < gap; g++) tick();
      applyStimulus($urandom_range(0, 2) != 0, note);
    end
    waitIdle(low);
    rand_clk = 1'b0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
